// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for one pipeline stage boundary: upstream entry, downstream entry, flush and halt status.
// master = producer/consumer side around the stage, slave = the stage register itself.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 80,
  parameter int CTRL_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              in_halt;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic              out_halt;
  logic              flush;
  logic              halted;

  modport master (
    output in_valid, in_data, in_ctrl, in_halt, out_ready, flush,
    input  in_ready, out_valid, out_data, out_ctrl, out_halt, halted
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, in_halt, out_ready, flush,
    output in_ready, out_valid, out_data, out_ctrl, out_halt, halted
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage register with flush, bubble zeroing of ctrl/halt and sticky halt tracking.
// Latency 1 cycle; capacity 1, or 2 with PIPE_SKID_EN (skid entry, in_ready free of any out_ready path).
// Backpressure: in_ready drops while full and blocked, during flush, after a halt entry, and in reset.
module pipe_stage_reg #(
  parameter int DATA_W = 80,
  parameter int CTRL_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  pipe_stage_reg_if.slave io_bus
);

  typedef struct packed {
    logic [DATA_W-1:0] dat;
    logic [CTRL_W-1:0] ctrl;
    logic              halt;
  } entry_t;

  entry_t w_in_ent;
  entry_t r_main_ent;
  logic   r_main_vld;
  logic   r_halt_pend;
  logic   r_halted;
  logic   w_rdy_core;
  logic   w_in_xfer;
  logic   w_out_xfer;

  assign w_in_ent = {io_bus.in_data, io_bus.in_ctrl, io_bus.in_halt};

`ifdef PIPE_SKID_EN
  entry_t r_skid_ent;
  logic   r_skid_vld;

  assign w_rdy_core = !io_bus.flush && !r_halt_pend && !r_skid_vld;
`else
  assign w_rdy_core = !io_bus.flush && !r_halt_pend && (!r_main_vld || io_bus.out_ready);
`endif

  // Flops are held in reset while rst is low, so rst only needs to gate the port.
  assign w_in_xfer  = io_bus.in_valid && w_rdy_core;
  assign w_out_xfer = r_main_vld && io_bus.out_ready;

`ifdef PIPE_SKID_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main_vld <= 1'b0;
      r_main_ent <= '0;
      r_skid_vld <= 1'b0;
      r_skid_ent <= '0;
    end else if (io_bus.flush) begin
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (w_out_xfer) begin
      if (r_skid_vld) begin
        r_main_ent <= r_skid_ent;
        r_skid_vld <= 1'b0;
      end else if (w_in_xfer) begin
        r_main_ent <= w_in_ent;
      end else begin
        r_main_vld <= 1'b0;
      end
    end else if (w_in_xfer) begin
      if (!r_main_vld) begin
        r_main_vld <= 1'b1;
        r_main_ent <= w_in_ent;
      end else begin
        r_skid_vld <= 1'b1;
        r_skid_ent <= w_in_ent;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main_vld <= 1'b0;
      r_main_ent <= '0;
    end else if (io_bus.flush) begin
      r_main_vld <= 1'b0;
    end else if (w_in_xfer) begin
      r_main_vld <= 1'b1;
      r_main_ent <= w_in_ent;
    end else if (w_out_xfer) begin
      r_main_vld <= 1'b0;
    end
  end
`endif

  // halted survives flush: the halt has already left the stage and been seen downstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_halt_pend <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      if (io_bus.flush) begin
        r_halt_pend <= 1'b0;
      end else if (w_in_xfer && io_bus.in_halt) begin
        r_halt_pend <= 1'b1;
      end
      if (w_out_xfer && r_main_ent.halt) begin
        r_halted <= 1'b1;
      end
    end
  end

  assign io_bus.in_ready  = rst && w_rdy_core;
  assign io_bus.out_valid = r_main_vld;
  assign io_bus.out_data  = r_main_ent.dat;
  assign io_bus.out_ctrl  = r_main_vld ? r_main_ent.ctrl : '0;
  assign io_bus.out_halt  = r_main_vld && r_main_ent.halt;
  assign io_bus.halted    = r_halted;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: model is a bounded queue of entries plus halt/flush flags.
module tb_pipe_stage_reg;
  localparam int DW = 80;
  localparam int CW = 8;
`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic          h;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();
  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (.clk(clk), .rst(rst), .io_bus(bus));

  ent_t          q[$];
  bit            hp;
  bit            exp_halted;
  bit            exp_in_rdy;
  logic [DW-1:0] last_head;
  int            n_checks = 0;
  int            n_pass = 0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Acceptance rule straight from the stage's contract: room in a queue of CAP entries.
  function automatic void predict_rdy();
    if (CAP == 2) exp_in_rdy = rst && !bus.flush && !hp && (q.size() < 2);
    else          exp_in_rdy = rst && !bus.flush && !hp && (q.size() == 0 || bus.out_ready);
  endfunction

  // Monitor: mid-cycle, compare visible outputs and retire the head on an output transfer.
  always @(negedge clk) begin
    chk("in_ready", 96'(bus.in_ready), 96'(exp_in_rdy));
    chk("out_valid", 96'(bus.out_valid), 96'(q.size() > 0));
    chk("halted", 96'(bus.halted), 96'(exp_halted));
    if (q.size() > 0) begin
      chk("out_data", 96'(bus.out_data), 96'(q[0].d));
      chk("out_ctrl", 96'(bus.out_ctrl), 96'(q[0].c));
      chk("out_halt", 96'(bus.out_halt), 96'(q[0].h));
      last_head = q[0].d;
      if (bus.out_ready && rst) begin
        if (q[0].h) exp_halted = 1'b1;
        void'(q.pop_front());
      end
    end else begin
      chk("bubble_ctrl", 96'(bus.out_ctrl), 96'(0));
      chk("bubble_halt", 96'(bus.out_halt), 96'(0));
      chk("held_data", 96'(bus.out_data), 96'(last_head));
    end
  end

  // One clock: commit the previous cycle's inputs to the model, then drive new ones.
  task automatic cycle(input bit iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input bit ih, input bit ordy, input bit fl);
    @(posedge clk);
    if (rst) begin
      if (bus.flush) begin
        q.delete();
        hp = 1'b0;
      end else if (bus.in_valid && exp_in_rdy) begin
        q.push_back('{bus.in_data, bus.in_ctrl, bus.in_halt});
        if (bus.in_halt) hp = 1'b1;
      end
    end
    #1;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.in_ctrl   = c;
    bus.in_halt   = ih;
    bus.out_ready = ordy;
    bus.flush     = fl;
    predict_rdy();
  endtask

  task automatic idle(input bit ordy);
    cycle(1'b0, '0, '0, 1'b0, ordy, 1'b0);
  endtask

  // Called just after a cycle() returns: drop rst between edges, check, hold one edge, release.
  task automatic async_reset(input string tag);
    #2 rst = 1'b0;
    #1;
    chk({tag, "_rst_out_valid"}, 96'(bus.out_valid), 96'(0));
    chk({tag, "_rst_out_ctrl"}, 96'(bus.out_ctrl), 96'(0));
    chk({tag, "_rst_out_data"}, 96'(bus.out_data), 96'(0));
    chk({tag, "_rst_halted"}, 96'(bus.halted), 96'(0));
    chk({tag, "_rst_in_ready"}, 96'(bus.in_ready), 96'(0));
    q.delete();
    hp = 1'b0;
    exp_halted = 1'b0;
    last_head = '0;
    predict_rdy();
    cycle(1'b1, 80'h77, 8'h81, 1'b0, 1'b1, 1'b0);
    #2 rst = 1'b1;
    predict_rdy();
  endtask

  logic [95:0] rnd;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_ctrl   = '0;
    bus.in_halt   = 1'b0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    hp = 1'b0;
    exp_halted = 1'b0;
    last_head = '0;
    exp_in_rdy = 1'b0;
    #1;
    async_reset("init");

    // Streaming at full rate
    for (int i = 1; i <= 4; i++) cycle(1'b1, DW'(i), 8'h81, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Back-pressure for 3 cycles, then release
    for (int i = 5; i <= 7; i++) cycle(1'b1, DW'(i), 8'h42, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Flush with the stage full and a new entry offered
    cycle(1'b1, 80'hA1, 8'h11, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 80'hA2, 8'h12, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 80'hA3, 8'h13, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    idle(1'b1);

    // Halt squashed by flush before it leaves
    cycle(1'b1, 80'hB1, 8'h21, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 80'hB2, 8'h22, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 80'hB3, 8'h23, 1'b0, 1'b1, 1'b0);
    idle(1'b1);

    // Halt that leaves, then a flush that must not clear halted
    cycle(1'b1, 80'hC1, 8'h31, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 80'hC2, 8'h32, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    idle(1'b1);

    // Reset asserted mid-stream
    cycle(1'b1, 80'hD1, 8'h41, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 80'hD2, 8'h42, 1'b0, 1'b0, 1'b0);
    async_reset("mid");
    cycle(1'b1, 80'hE1, 8'h51, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      rnd = {$urandom(), $urandom(), $urandom()};
      cycle($urandom_range(0, 9) < 7, rnd[DW-1:0], CW'($urandom()),
            $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 6,
            $urandom_range(0, 19) == 0);
      if (i % 200 == 199) async_reset("rand");
    end

    cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
